// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant decision; purely combinational.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic    a_req,
  input  logic    b_req,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = REQ_A;
    // A tie goes to whoever was not served last; a lone request always wins.
    if (a_req && b_req) begin
      grant_id = other_id(last_grant);
    end else if (b_req) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (A) and loader/debug (B) requesters onto one synchronous
// single-port RAM; each transaction is IDLE -> ACCESS -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  req_id_t           last_q, gid_q, grant_id;
  logic              grant_valid;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  mem_arb_rr u_rr (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gid_q     <= REQ_A;
      last_q    <= REQ_B;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        gid_q <= grant_id;
        if (grant_id == REQ_A) begin
          we_q    <= a_we;
          addr_q  <= a_addr;
          wdata_q <= a_wdata;
        end else begin
          we_q    <= b_we;
          addr_q  <= b_addr;
          wdata_q <= b_wdata;
        end
      end
      if (state_q == RESP) begin
        last_q <= gid_q;
        if (!we_q) begin
          if (gid_q == REQ_A) a_rdata_q <= ram_rdata;
          else                b_rdata_q <= ram_rdata;
        end
      end
    end
  end

  // RAM read data arrives during RESP, so it is forwarded straight through on
  // the ack cycle and captured for the hold value afterwards.
  always_comb begin
    a_ack     = (state_q == RESP) && (gid_q == REQ_A);
    b_ack     = (state_q == RESP) && (gid_q == REQ_B);
    a_rdata   = (a_ack && !we_q) ? ram_rdata : a_rdata_q;
    b_rdata   = (b_ack && !we_q) ? ram_rdata : b_rdata_q;
    ram_we    = (state_q == ACCESS) && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    busy      = (state_q != IDLE);
  end

endmodule
